// File: rtl/alto_sram_controller.sv
// Wishbone classic slave driving an asynchronous 64K x 16 SRAM with programmable
// read/write wait states; every output comes straight from a flop.
module alto_sram_controller #(
   parameter int unsigned READ_WAIT  = 2,
   parameter int unsigned WRITE_WAIT = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [16:1] wb_adr_i,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   input  logic        wb_we_i,
   input  logic [1:0]  wb_sel_i,
   input  logic [15:0] wb_dat_i,
   output logic [15:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic [15:0] sram_adr_o,
   input  logic [15:0] sram_dq_i,
   output logic [15:0] sram_dq_o,
   output logic        sram_dq_oe_o,
   output logic        sram_ce_n_o,
   output logic        sram_oe_n_o,
   output logic        sram_we_n_o,
   output logic        sram_ub_n_o,
   output logic        sram_lb_n_o
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADR_W  = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_ACK   = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               abort_q, abort_d;
   logic               ack_d;
   logic [DATA_W-1:0]  dat_d;
   logic [ADR_W-1:0]   adr_d;
   logic [DATA_W-1:0]  dq_d;
   logic               dq_oe_d;
   logic               ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d;
   logic               req_c;

   assign req_c = wb_cyc_i & wb_stb_i & ~wb_ack_o;

   // Next-state and next-output logic; every output register defaults to hold.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      abort_d = abort_q;
      ack_d   = 1'b0;
      dat_d   = wb_dat_o;
      adr_d   = sram_adr_o;
      dq_d    = sram_dq_o;
      dq_oe_d = sram_dq_oe_o;
      ce_n_d  = sram_ce_n_o;
      oe_n_d  = sram_oe_n_o;
      we_n_d  = sram_we_n_o;
      ub_n_d  = sram_ub_n_o;
      lb_n_d  = sram_lb_n_o;

      unique case (state_q)
         ST_IDLE: begin
            if (req_c) begin
               adr_d   = wb_adr_i;
               dq_d    = wb_dat_i;
               ub_n_d  = ~wb_sel_i[1];
               lb_n_d  = ~wb_sel_i[0];
               abort_d = 1'b0;
               cnt_d   = wb_we_i ? CNT_W'(WRITE_WAIT - 1) : CNT_W'(READ_WAIT - 1);
               if (wb_sel_i == 2'b00) begin
                  // Nothing selected: acknowledge without touching the SRAM.
                  state_d = ST_ACK;
                  ack_d   = 1'b1;
               end else if (wb_we_i) begin
                  state_d = ST_WRITE;
                  ce_n_d  = 1'b0;
                  we_n_d  = 1'b0;
                  dq_oe_d = 1'b1;
               end else begin
                  state_d = ST_READ;
                  ce_n_d  = 1'b0;
                  oe_n_d  = 1'b0;
               end
            end
         end

         ST_READ: begin
            if (!wb_cyc_i) begin
               state_d = ST_IDLE;
               ce_n_d  = 1'b1;
               oe_n_d  = 1'b1;
               ub_n_d  = 1'b1;
               lb_n_d  = 1'b1;
            end else if (cnt_q == '0) begin
               state_d = ST_ACK;
               dat_d   = sram_dq_i;
               ce_n_d  = 1'b1;
               oe_n_d  = 1'b1;
               ack_d   = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_WRITE: begin
            // A write always finishes its pulse; a lost cycle only silences the ack.
            if (!wb_cyc_i) abort_d = 1'b1;
            if (cnt_q == '0) begin
               state_d = ST_ACK;
               we_n_d  = 1'b1;
               ack_d   = wb_cyc_i & ~abort_q;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_ACK: begin
            state_d = ST_IDLE;
            ce_n_d  = 1'b1;
            oe_n_d  = 1'b1;
            we_n_d  = 1'b1;
            dq_oe_d = 1'b0;
            ub_n_d  = 1'b1;
            lb_n_d  = 1'b1;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         abort_q      <= 1'b0;
         wb_ack_o     <= 1'b0;
         wb_dat_o     <= '0;
         sram_adr_o   <= '0;
         sram_dq_o    <= '0;
         sram_dq_oe_o <= 1'b0;
         sram_ce_n_o  <= 1'b1;
         sram_oe_n_o  <= 1'b1;
         sram_we_n_o  <= 1'b1;
         sram_ub_n_o  <= 1'b1;
         sram_lb_n_o  <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         abort_q      <= abort_d;
         wb_ack_o     <= ack_d;
         wb_dat_o     <= dat_d;
         sram_adr_o   <= adr_d;
         sram_dq_o    <= dq_d;
         sram_dq_oe_o <= dq_oe_d;
         sram_ce_n_o  <= ce_n_d;
         sram_oe_n_o  <= oe_n_d;
         sram_we_n_o  <= we_n_d;
         sram_ub_n_o  <= ub_n_d;
         sram_lb_n_o  <= lb_n_d;
      end
   end

endmodule

// File: tb/tb_alto_sram_controller.sv
// Directed bench for alto_sram_controller with a behavioural async SRAM model.
module tb_alto_sram_controller;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [16:1] wb_adr_i;
   logic        wb_stb_i, wb_cyc_i, wb_we_i;
   logic [1:0]  wb_sel_i;
   logic [15:0] wb_dat_i;
   logic [15:0] wb_dat_o;
   logic        wb_ack_o;
   logic [15:0] sram_adr_o, sram_dq_i, sram_dq_o;
   logic        sram_dq_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_ub_n_o, sram_lb_n_o;

   int errors = 0;
   int checks = 0;

   logic [15:0] mem [0:65535];

   always #5 clk_i = ~clk_i;

   alto_sram_controller #(.READ_WAIT(2), .WRITE_WAIT(2)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .wb_adr_i(wb_adr_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
      .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
      .sram_adr_o(sram_adr_o), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
      .sram_dq_oe_o(sram_dq_oe_o), .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o),
      .sram_we_n_o(sram_we_n_o), .sram_ub_n_o(sram_ub_n_o), .sram_lb_n_o(sram_lb_n_o)
   );

   // Async SRAM: reads while CE/OE low, writes selected bytes on the WE rising edge.
   assign sram_dq_i = (!sram_ce_n_o && !sram_oe_n_o) ? mem[sram_adr_o] : 16'hDEAD;

   always @(posedge sram_we_n_o) begin
      if (!sram_ce_n_o && sram_dq_oe_o) begin
         if (!sram_ub_n_o) mem[sram_adr_o][15:8] = sram_dq_o[15:8];
         if (!sram_lb_n_o) mem[sram_adr_o][7:0]  = sram_dq_o[7:0];
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_bus();
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      wb_adr_i = '0; wb_sel_i = 2'b00; wb_dat_i = '0;
   endtask

   // One transfer issued in the current cycle; collects strobe activity until ack + 1.
   task automatic run_xfer(input logic we, input logic [15:0] adr, input logic [1:0] sel,
                           input logic [15:0] dat,
                           output int ack_cyc, output int we_low, output int oe_low,
                           output int ce_low, output logic adr_ok, output logic dq_oe_ok,
                           output logic ub_w, output logic lb_w, output logic ack_dq_oe,
                           output logic post_dq_oe, output logic post_ack,
                           output logic [15:0] rdata);
      ack_cyc = -1; we_low = 0; oe_low = 0; ce_low = 0;
      adr_ok = 1'b1; dq_oe_ok = 1'b1; ub_w = 1'b1; lb_w = 1'b1; ack_dq_oe = 1'b0;
      rdata = 16'h0000;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
      wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = dat;
      for (int c = 1; c <= 20 && ack_cyc < 0; c++) begin
         step();
         if (!sram_we_n_o) begin
            we_low++;
            if (sram_adr_o !== adr) adr_ok = 1'b0;
            if (sram_dq_oe_o !== 1'b1) dq_oe_ok = 1'b0;
            ub_w = sram_ub_n_o;
            lb_w = sram_lb_n_o;
         end
         if (!sram_oe_n_o) oe_low++;
         if (!sram_ce_n_o) ce_low++;
         if (wb_ack_o) begin
            ack_cyc   = c;
            rdata     = wb_dat_o;
            ack_dq_oe = sram_dq_oe_o;
         end
      end
      idle_bus();
      step();
      post_dq_oe = sram_dq_oe_o;
      post_ack   = wb_ack_o;
   endtask

   int          ack_cyc, we_low, oe_low, ce_low;
   logic        adr_ok, dq_oe_ok, ub_w, lb_w, ack_dq_oe, post_dq_oe, post_ack;
   logic [15:0] rdata;

   task automatic test_reset();
      idle_bus();
      rst_ni = 1'b0;
      repeat (3) step();
      rst_ni = 1'b1;
      step();
      checks++;
      if ({sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_ub_n_o, sram_lb_n_o} !== 5'b11111) begin
         errors++;
         $display("FAIL reset_strobes: got %b want 11111",
                  {sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_ub_n_o, sram_lb_n_o});
      end
      checks++;
      if (sram_dq_oe_o !== 1'b0 || wb_ack_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_oe_ack: dq_oe=%b ack=%b want 0 0", sram_dq_oe_o, wb_ack_o);
      end
      checks++;
      if (wb_dat_o !== 16'h0000 || sram_adr_o !== 16'h0000) begin
         errors++;
         $display("FAIL reset_data: dat=%h adr=%h want 0000 0000", wb_dat_o, sram_adr_o);
      end
   endtask

   task automatic test_write();
      run_xfer(1'b1, 16'h1234, 2'b11, 16'hBEEF, ack_cyc, we_low, oe_low, ce_low, adr_ok,
               dq_oe_ok, ub_w, lb_w, ack_dq_oe, post_dq_oe, post_ack, rdata);
      checks++;
      if (we_low !== 2) begin
         errors++; $display("FAIL write_we_len: got %0d want 2", we_low);
      end
      checks++;
      if (adr_ok !== 1'b1 || dq_oe_ok !== 1'b1) begin
         errors++; $display("FAIL write_adr_oe: adr_ok=%b dq_oe_ok=%b want 1 1", adr_ok, dq_oe_ok);
      end
      checks++;
      if (ack_cyc !== 3) begin
         errors++; $display("FAIL write_ack_cycle: got %0d want 3", ack_cyc);
      end
      checks++;
      if (ack_dq_oe !== 1'b1 || ce_low !== 3) begin
         errors++; $display("FAIL write_hold: ack_dq_oe=%b ce_low=%0d want 1 3", ack_dq_oe, ce_low);
      end
      checks++;
      if (post_dq_oe !== 1'b0 || post_ack !== 1'b0) begin
         errors++; $display("FAIL write_post: dq_oe=%b ack=%b want 0 0", post_dq_oe, post_ack);
      end
      checks++;
      if (mem[16'h1234] !== 16'hBEEF) begin
         errors++; $display("FAIL write_mem: got %h want BEEF", mem[16'h1234]);
      end
   endtask

   task automatic test_read();
      run_xfer(1'b0, 16'h1234, 2'b11, 16'h0000, ack_cyc, we_low, oe_low, ce_low, adr_ok,
               dq_oe_ok, ub_w, lb_w, ack_dq_oe, post_dq_oe, post_ack, rdata);
      checks++;
      if (oe_low !== 2 || we_low !== 0) begin
         errors++; $display("FAIL read_strobes: oe_low=%0d we_low=%0d want 2 0", oe_low, we_low);
      end
      checks++;
      if (ack_cyc !== 3) begin
         errors++; $display("FAIL read_ack_cycle: got %0d want 3", ack_cyc);
      end
      checks++;
      if (rdata !== 16'hBEEF) begin
         errors++; $display("FAIL read_data: got %h want BEEF", rdata);
      end
      checks++;
      if (post_ack !== 1'b0) begin
         errors++; $display("FAIL read_ack_width: got %b want 0", post_ack);
      end
   endtask

   task automatic test_byte_write();
      run_xfer(1'b1, 16'h1234, 2'b01, 16'hAA55, ack_cyc, we_low, oe_low, ce_low, adr_ok,
               dq_oe_ok, ub_w, lb_w, ack_dq_oe, post_dq_oe, post_ack, rdata);
      checks++;
      if (ub_w !== 1'b1 || lb_w !== 1'b0) begin
         errors++; $display("FAIL byte_enables: ub=%b lb=%b want 1 0", ub_w, lb_w);
      end
      run_xfer(1'b0, 16'h1234, 2'b11, 16'h0000, ack_cyc, we_low, oe_low, ce_low, adr_ok,
               dq_oe_ok, ub_w, lb_w, ack_dq_oe, post_dq_oe, post_ack, rdata);
      checks++;
      if (rdata !== 16'hBE55 || ack_cyc !== 3) begin
         errors++; $display("FAIL byte_readback: got %h at cycle %0d want BE55 at 3", rdata, ack_cyc);
      end
   endtask

   task automatic test_sel_zero();
      run_xfer(1'b0, 16'h1234, 2'b00, 16'h0000, ack_cyc, we_low, oe_low, ce_low, adr_ok,
               dq_oe_ok, ub_w, lb_w, ack_dq_oe, post_dq_oe, post_ack, rdata);
      checks++;
      if (ack_cyc !== 1) begin
         errors++; $display("FAIL sel0_ack_cycle: got %0d want 1", ack_cyc);
      end
      checks++;
      if (ce_low !== 0 || oe_low !== 0 || we_low !== 0) begin
         errors++; $display("FAIL sel0_strobes: ce=%0d oe=%0d we=%0d want 0 0 0", ce_low, oe_low, we_low);
      end
      checks++;
      if (rdata !== 16'hBE55) begin
         errors++; $display("FAIL sel0_data_hold: got %h want BE55", rdata);
      end
   endtask

   task automatic test_back_to_back();
      logic dq_oe_h [0:31];
      logic oe_n_h  [0:31];
      logic we_n_h  [0:31];
      int   acks = 0, ack1 = -1, ack2 = -1, last_we = -1, first_oe = -1;
      logic gap = 1'b0, clash = 1'b0;
      logic [15:0] rd = 16'h0000;
      for (int i = 0; i < 32; i++) begin
         dq_oe_h[i] = 1'b0; oe_n_h[i] = 1'b1; we_n_h[i] = 1'b1;
      end
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
      wb_adr_i = 16'h0100; wb_sel_i = 2'b11; wb_dat_i = 16'h1357;
      for (int c = 1; c < 30 && acks < 2; c++) begin
         step();
         dq_oe_h[c] = sram_dq_oe_o; oe_n_h[c] = sram_oe_n_o; we_n_h[c] = sram_we_n_o;
         if (sram_dq_oe_o && !sram_oe_n_o) clash = 1'b1;
         if (wb_ack_o) begin
            acks++;
            if (acks == 1) begin
               ack1 = c;
               wb_we_i = 1'b0; wb_dat_i = 16'hFFFF;
            end else begin
               ack2 = c;
               rd = wb_dat_o;
            end
         end
      end
      idle_bus();
      for (int c = 0; c < 4; c++) begin
         step();
         if (wb_ack_o) acks++;
      end
      for (int c = 1; c < 30; c++) if (!we_n_h[c]) last_we = c;
      for (int c = 29; c > 0; c--) if (!oe_n_h[c] && c > last_we) first_oe = c;
      for (int c = 1; c < 30; c++)
         if (c > last_we && c < first_oe && !dq_oe_h[c] && oe_n_h[c]) gap = 1'b1;
      checks++;
      if (acks !== 2 || ack1 !== 3 || ack2 !== 7) begin
         errors++; $display("FAIL b2b_acks: count=%0d at %0d,%0d want 2 at 3,7", acks, ack1, ack2);
      end
      checks++;
      if (gap !== 1'b1 || clash !== 1'b0) begin
         errors++; $display("FAIL b2b_turnaround: gap=%b clash=%b want 1 0", gap, clash);
      end
      checks++;
      if (rd !== 16'h1357) begin
         errors++; $display("FAIL b2b_read_data: got %h want 1357", rd);
      end
   endtask

   task automatic test_cyc_drop_read();
      int acks = 0;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
      wb_adr_i = 16'h1234; wb_sel_i = 2'b11;
      step();
      checks++;
      if (sram_oe_n_o !== 1'b0 || sram_ce_n_o !== 1'b0) begin
         errors++; $display("FAIL rdrop_started: oe_n=%b ce_n=%b want 0 0", sram_oe_n_o, sram_ce_n_o);
      end
      idle_bus();
      step();
      checks++;
      if ({sram_ce_n_o, sram_oe_n_o, sram_ub_n_o, sram_lb_n_o} !== 4'b1111) begin
         errors++;
         $display("FAIL rdrop_release: got %b want 1111",
                  {sram_ce_n_o, sram_oe_n_o, sram_ub_n_o, sram_lb_n_o});
      end
      if (wb_ack_o) acks++;
      for (int c = 0; c < 6; c++) begin
         step();
         if (wb_ack_o) acks++;
      end
      checks++;
      if (acks !== 0 || wb_dat_o !== 16'h1357) begin
         errors++; $display("FAIL rdrop_no_ack: acks=%0d dat=%h want 0 1357", acks, wb_dat_o);
      end
   endtask

   task automatic test_cyc_drop_write();
      int acks = 0, wl = 0;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
      wb_adr_i = 16'h0200; wb_sel_i = 2'b11; wb_dat_i = 16'h2468;
      step();
      if (!sram_we_n_o) wl++;
      idle_bus();
      for (int c = 0; c < 8; c++) begin
         step();
         if (!sram_we_n_o) wl++;
         if (wb_ack_o) acks++;
      end
      checks++;
      if (wl !== 2 || acks !== 0) begin
         errors++; $display("FAIL wdrop_pulse: we_low=%0d acks=%0d want 2 0", wl, acks);
      end
      run_xfer(1'b0, 16'h0200, 2'b11, 16'h0000, ack_cyc, we_low, oe_low, ce_low, adr_ok,
               dq_oe_ok, ub_w, lb_w, ack_dq_oe, post_dq_oe, post_ack, rdata);
      checks++;
      if (rdata !== 16'h2468) begin
         errors++; $display("FAIL wdrop_readback: got %h want 2468", rdata);
      end
   endtask

   task automatic test_reset_mid_write();
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
      wb_adr_i = 16'h0300; wb_sel_i = 2'b11; wb_dat_i = 16'h0F0F;
      step();
      checks++;
      if (sram_we_n_o !== 1'b0) begin
         errors++; $display("FAIL rst_mid_started: we_n=%b want 0", sram_we_n_o);
      end
      #2 rst_ni = 1'b0;
      #1;
      checks++;
      if ({sram_we_n_o, sram_ce_n_o, sram_dq_oe_o, wb_ack_o} !== 4'b1100) begin
         errors++;
         $display("FAIL rst_mid_async: we_n,ce_n,dq_oe,ack=%b want 1100",
                  {sram_we_n_o, sram_ce_n_o, sram_dq_oe_o, wb_ack_o});
      end
      idle_bus();
      step();
      rst_ni = 1'b1;
      step();
      run_xfer(1'b0, 16'h0000, 2'b00, 16'h0000, ack_cyc, we_low, oe_low, ce_low, adr_ok,
               dq_oe_ok, ub_w, lb_w, ack_dq_oe, post_dq_oe, post_ack, rdata);
      checks++;
      if (ack_cyc !== 1 || rdata !== 16'h0000) begin
         errors++; $display("FAIL rst_mid_idle: ack at %0d dat=%h want 1 0000", ack_cyc, rdata);
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
      test_reset();
      test_write();
      test_read();
      test_byte_write();
      test_sel_zero();
      test_back_to_back();
      test_cyc_drop_read();
      test_cyc_drop_write();
      test_reset_mid_write();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
